// File: rtl/control_seq_mc_pkg.sv
// Shared definitions for the multicycle control sequencer: opcodes, ALU codes,
// FSM/PC-operation encodings and the instruction field splitter.
package control_seq_mc_pkg;

  localparam int MAX_REGW = 8;
  localparam int MAX_IW   = 4 + 3 * MAX_REGW;
  localparam int OFFW     = 2 * MAX_REGW;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BRZ  = 4'hA;
  localparam logic [3:0] OP_BNZ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;

  localparam logic [3:0] FS_NONE = 4'h0;
  localparam logic [3:0] FS_ADD  = 4'h1;
  localparam logic [3:0] FS_SUB  = 4'h2;
  localparam logic [3:0] FS_AND  = 4'h3;
  localparam logic [3:0] FS_OR   = 4'h4;
  localparam logic [3:0] FS_XOR  = 4'h5;
  localparam logic [3:0] FS_NOT  = 4'h6;
  localparam logic [3:0] FS_MOV  = 4'h7;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IF   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_REL  = 2'd2,
    PC_LOAD = 2'd3
  } pc_op_t;

  typedef struct packed {
    logic [3:0]          opcode;
    logic [MAX_REGW-1:0] dr;
    logic [MAX_REGW-1:0] sa;
    logic [MAX_REGW-1:0] sb;
    logic [OFFW-1:0]     offset;
  } ir_fields_t;

  // Fields are right-aligned in the returned struct; offset is raw (unextended).
  function automatic ir_fields_t split_ir(input logic [MAX_IW-1:0] word, input int regw);
    ir_fields_t f;
    logic [MAX_IW-1:0] fmask;
    logic [MAX_IW-1:0] omask;
    fmask    = {MAX_IW{1'b1}} >> (MAX_IW - regw);
    omask    = {MAX_IW{1'b1}} >> (MAX_IW - 2 * regw);
    f.opcode = 4'((word >> (3 * regw)) & MAX_IW'(4'hF));
    f.dr     = MAX_REGW'((word >> (2 * regw)) & fmask);
    f.sa     = MAX_REGW'((word >> regw) & fmask);
    f.sb     = MAX_REGW'(word & fmask);
    f.offset = OFFW'(word & omask);
    return f;
  endfunction

endpackage

// File: rtl/control_seq_mc_seq_pc_unit.sv
// Program counter: hold, increment, signed relative add or absolute load,
// all modulo 2^PCW.
module seq_pc_unit
  import control_seq_mc_pkg::*;
#(
  parameter int             PCW      = 8,
  parameter logic [PCW-1:0] RESET_PC = {PCW{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     pc_op,
  input  logic [PCW-1:0] rel_off,
  input  logic [PCW-1:0] load_val,
  output logic [PCW-1:0] pc
);

  logic [PCW-1:0] pc_r;
  logic [PCW-1:0] pc_nx_s;

  // Next PC selection; relative offsets arrive already sign-extended to PCW.
  always_comb begin
    pc_nx_s = pc_r;
    case (pc_op)
      PC_INC:  pc_nx_s = pc_r + {{(PCW-1){1'b0}}, 1'b1};
      PC_REL:  pc_nx_s = pc_r + rel_off;
      PC_LOAD: pc_nx_s = load_val;
      default: pc_nx_s = pc_r;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_nx_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/control_seq_mc.sv
// Multicycle control sequencer: fetch/execute/memory/halt FSM with decode,
// driving every datapath control line combinationally from state and IR.
module control_seq_mc
  import control_seq_mc_pkg::*;
#(
  parameter int             REGW     = 4,
  parameter int             PCW      = 8,
  parameter int             DW       = 16,
  parameter logic [PCW-1:0] RESET_PC = {PCW{1'b0}},
  localparam int            IW       = 4 + 3 * REGW
) (
  input  logic            clk_main,
  input  logic            reset,
  input  logic [IW-1:0]   InstructIn,
  input  logic            imem_ack,
  input  logic            dmem_ack,
  input  logic [DW-1:0]   BusA,
  input  logic            Z,
  input  logic            run,
  output logic            imem_req,
  output logic            dmem_req,
  output logic [PCW-1:0]  PC,
  output logic [REGW-1:0] DR,
  output logic [REGW-1:0] SA,
  output logic [REGW-1:0] SB,
  output logic [3:0]      FS,
  output logic            MB,
  output logic            MM,
  output logic            MD,
  output logic            MW,
  output logic            RW,
  output logic            halted,
  output logic            illegal
);

  localparam int OW = 2 * REGW;

  state_t              state_r;
  state_t              state_nx_s;
  logic [IW-1:0]       ir_r;
  logic                ir_load_s;
  pc_op_t              pc_op_s;
  ir_fields_t          fld_s;
  logic [3:0]          op_s;
  logic [OW-1:0]       off_s;
  logic [PCW+OW-1:0]   off_ext_s;
  logic [PCW+DW-1:0]   jmp_ext_s;
  logic                unused_s;

  assign fld_s     = split_ir(MAX_IW'(ir_r), REGW);
  assign op_s      = fld_s.opcode;
  assign DR        = fld_s.dr[REGW-1:0];
  assign SA        = fld_s.sa[REGW-1:0];
  assign SB        = fld_s.sb[REGW-1:0];
  assign off_s     = fld_s.offset[OW-1:0];
  // Widen both ways so the PCW slice is right whether PCW is wider or narrower.
  assign off_ext_s = {{PCW{off_s[OW-1]}}, off_s};
  assign jmp_ext_s = {{PCW{1'b0}}, BusA};
  assign unused_s  = ^{fld_s, off_ext_s, jmp_ext_s};

  // State and instruction register.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state_r <= ST_BOOT;
      ir_r    <= {IW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (ir_load_s) begin
        ir_r <= InstructIn;
      end
    end
  end

  // Next state, PC operation and datapath controls.
  always_comb begin
    state_nx_s = state_r;
    pc_op_s    = PC_HOLD;
    ir_load_s  = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    FS         = FS_NONE;
    MB         = 1'b0;
    MM         = 1'b0;
    MD         = 1'b0;
    MW         = 1'b0;
    RW         = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_r)
      ST_BOOT: state_nx_s = ST_IF;
      ST_IF: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load_s  = 1'b1;
          state_nx_s = ST_EX;
        end else begin
          state_nx_s = ST_IF;
        end
      end
      ST_EX: begin
        state_nx_s = ST_IF;
        pc_op_s    = PC_INC;
        case (op_s)
          OP_NOP: pc_op_s = PC_INC;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV: begin
            FS = op_s;
            RW = 1'b1;
          end
          OP_LD, OP_ST: begin
            state_nx_s = ST_MEM;
            pc_op_s    = PC_HOLD;
          end
          OP_BRZ: pc_op_s = Z ? PC_REL : PC_INC;
          OP_BNZ: pc_op_s = Z ? PC_INC : PC_REL;
          OP_JMP: pc_op_s = PC_LOAD;
          OP_HALT: begin
            state_nx_s = ST_HALT;
            pc_op_s    = PC_HOLD;
          end
          default: illegal = 1'b1;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        MM       = 1'b1;
        if (op_s == OP_ST) begin
          MW = 1'b1;
        end else begin
          MD = 1'b1;
          RW = dmem_ack;
        end
        if (dmem_ack) begin
          pc_op_s    = PC_INC;
          state_nx_s = ST_IF;
        end else begin
          state_nx_s = ST_MEM;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run) begin
          pc_op_s    = PC_INC;
          state_nx_s = ST_IF;
        end else begin
          state_nx_s = ST_HALT;
        end
      end
      default: state_nx_s = ST_BOOT;
    endcase
  end

  seq_pc_unit #(
    .PCW      (PCW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk_main),
    .rst      (reset),
    .pc_op    (pc_op_s),
    .rel_off  (off_ext_s[PCW-1:0]),
    .load_val (jmp_ext_s[PCW-1:0]),
    .pc       (PC)
  );

endmodule

// File: tb/tb_control_seq_mc.sv
// Directed bench for control_seq_mc with a scoreboard queue of expected values.
module tb_control_seq_mc;

  localparam int REGW = 4;
  localparam int PCW  = 8;
  localparam int DW   = 16;
  localparam int IW   = 16;

  logic            clk_main = 1'b0;
  logic            reset;
  logic [IW-1:0]   InstructIn;
  logic            imem_ack;
  logic            dmem_ack;
  logic [DW-1:0]   BusA;
  logic            Z;
  logic            run;
  logic            imem_req;
  logic            dmem_req;
  logic [PCW-1:0]  PC;
  logic [REGW-1:0] DR;
  logic [REGW-1:0] SA;
  logic [REGW-1:0] SB;
  logic [3:0]      FS;
  logic            MB;
  logic            MM;
  logic            MD;
  logic            MW;
  logic            RW;
  logic            halted;
  logic            illegal;

  logic [12:0]     ctrl_s;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  pc_m;

  always #5 clk_main = ~clk_main;

  control_seq_mc #(
    .REGW(REGW), .PCW(PCW), .DW(DW), .RESET_PC(8'h00)
  ) dut (
    .clk_main(clk_main), .reset(reset), .InstructIn(InstructIn),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .BusA(BusA), .Z(Z), .run(run),
    .imem_req(imem_req), .dmem_req(dmem_req), .PC(PC), .DR(DR), .SA(SA), .SB(SB),
    .FS(FS), .MB(MB), .MM(MM), .MD(MD), .MW(MW), .RW(RW),
    .halted(halted), .illegal(illegal)
  );

  assign ctrl_s = {imem_req, dmem_req, FS, MB, MM, MD, MW, RW, halted, illegal};

  function automatic logic [12:0] mk_ctrl(input logic ireq, input logic dreq,
                                          input logic [3:0] fs, input logic mm,
                                          input logic md, input logic mw,
                                          input logic rw, input logic hl,
                                          input logic il);
    return {ireq, dreq, fs, 1'b0, mm, md, mw, rw, hl, il};
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] val);
    sb_q.push_back('{tag, val});
  endtask

  task automatic check_next(input logic [31:0] obs);
    sb_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty observed %0h expected queued entry", obs);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Starts at a negedge in IF; ack arrives after 'waits' stall cycles.
  task automatic fetch(input logic [15:0] instr, input int waits);
    for (int i = 0; i <= waits; i++) begin
      expect_val("if_ctrl", 32'(mk_ctrl(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
      expect_val("if_pc", 32'(pc_m));
    end
    for (int i = 0; i <= waits; i++) begin
      imem_ack   = (i == waits);
      InstructIn = (i == waits) ? instr : 16'hEEEE;
      #1;
      check_next(32'(ctrl_s));
      check_next(32'(PC));
      @(negedge clk_main);
    end
    imem_ack   = 1'b0;
    InstructIn = 16'hEEEE;
  endtask

  task automatic ex_step(input logic [12:0] exp_ctrl, input logic zin,
                         input logic [15:0] bus, input logic [7:0] next_pc);
    Z    = zin;
    BusA = bus;
    expect_val("ex_ctrl", 32'(exp_ctrl));
    expect_val("ex_pc", 32'(pc_m));
    #1;
    check_next(32'(ctrl_s));
    check_next(32'(PC));
    @(negedge clk_main);
    pc_m = next_pc;
  endtask

  task automatic mem_step(input logic is_st, input int waits);
    for (int i = 0; i <= waits; i++) begin
      expect_val(is_st ? "st_ctrl" : "ld_ctrl",
                 32'(mk_ctrl(1'b0, 1'b1, 4'h0, 1'b1, !is_st, is_st,
                             !is_st && (i == waits), 1'b0, 1'b0)));
      expect_val("mem_pc", 32'(pc_m));
    end
    for (int i = 0; i <= waits; i++) begin
      dmem_ack = (i == waits);
      #1;
      check_next(32'(ctrl_s));
      check_next(32'(PC));
      @(negedge clk_main);
    end
    dmem_ack = 1'b0;
    pc_m     = pc_m + 8'd1;
  endtask

  logic [12:0] zero_c;
  logic [12:0] halt_c;

  initial begin
    zero_c     = mk_ctrl(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    halt_c     = mk_ctrl(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    dmem_ack   = 1'b0;
    InstructIn = 16'h1312;
    BusA       = 16'h0000;
    Z          = 1'b0;
    run        = 1'b0;
    pc_m       = 8'h00;

    // Reset with imem_ack high: everything reads zero.
    repeat (2) @(negedge clk_main);
    expect_val("rst_ctrl", 32'(zero_c));
    expect_val("rst_pc", 32'h0);
    expect_val("rst_fields", 32'h0);
    check_next(32'(ctrl_s));
    check_next(32'(PC));
    check_next(32'({DR, SA, SB}));
    reset    = 1'b0;
    imem_ack = 1'b0;
    expect_val("boot_ctrl", 32'(zero_c));
    #1;
    check_next(32'(ctrl_s));
    @(negedge clk_main);

    // ADD R3,R1,R2 with two fetch stalls.
    fetch(16'h1312, 2);
    expect_val("add_fields", 32'h312);
    check_next(32'({DR, SA, SB}));
    ex_step(mk_ctrl(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 16'h0, 8'h01);

    // LD and ST, data ack on the third MEM cycle.
    fetch(16'h8450, 0);
    ex_step(zero_c, 1'b0, 16'h0, pc_m);
    mem_step(1'b0, 2);
    fetch(16'h9051, 0);
    ex_step(zero_c, 1'b0, 16'h0, pc_m);
    mem_step(1'b1, 2);

    // JMP truncates BusA to PCW bits.
    fetch(16'hC100, 0);
    ex_step(zero_c, 1'b0, 16'h1234, 8'h34);
    fetch(16'hC100, 0);
    ex_step(zero_c, 1'b0, 16'h0100, 8'h00);

    // Branches: taken backwards with wrap, taken forward with wrap, not taken.
    fetch(16'hA0FE, 0);
    ex_step(zero_c, 1'b1, 16'h0, 8'hFE);
    fetch(16'h0000, 0);
    ex_step(zero_c, 1'b0, 16'h0, 8'hFF);
    fetch(16'hB002, 0);
    ex_step(zero_c, 1'b0, 16'h0, 8'h01);
    fetch(16'hA0FE, 0);
    ex_step(zero_c, 1'b0, 16'h0, 8'h02);
    fetch(16'hB002, 0);
    ex_step(zero_c, 1'b1, 16'h0, 8'h03);

    // HALT held five cycles, then resumed with a run pulse.
    fetch(16'hD000, 0);
    ex_step(zero_c, 1'b0, 16'h0, pc_m);
    for (int i = 0; i < 5; i++) begin
      expect_val("halt_ctrl", 32'(halt_c));
      expect_val("halt_pc", 32'(pc_m));
      #1;
      check_next(32'(ctrl_s));
      check_next(32'(PC));
      @(negedge clk_main);
    end
    run = 1'b1;
    @(negedge clk_main);
    run  = 1'b0;
    pc_m = pc_m + 8'd1;

    // Undefined opcode pulses illegal once and behaves as NOP.
    fetch(16'hE000, 0);
    ex_step(mk_ctrl(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, 16'h0, 8'h05);
    fetch(16'h2123, 0);
    ex_step(mk_ctrl(1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 16'h0, 8'h06);

    // Reset in the middle of a store.
    fetch(16'h9051, 0);
    ex_step(zero_c, 1'b0, 16'h0, pc_m);
    expect_val("st_pre_rst", 32'(mk_ctrl(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
    #1;
    check_next(32'(ctrl_s));
    #1;
    reset    = 1'b1;
    dmem_ack = 1'b1;
    imem_ack = 1'b1;
    pc_m     = 8'h00;
    expect_val("st_rst_ctrl", 32'(zero_c));
    expect_val("st_rst_pc", 32'h0);
    #1;
    check_next(32'(ctrl_s));
    check_next(32'(PC));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_main);
      expect_val("rst_hold_ctrl", 32'(zero_c));
      check_next(32'(ctrl_s));
    end
    reset    = 1'b0;
    dmem_ack = 1'b0;
    imem_ack = 1'b0;
    expect_val("boot2_ctrl", 32'(zero_c));
    #1;
    check_next(32'(ctrl_s));
    @(negedge clk_main);
    fetch(16'h0000, 0);
    ex_step(zero_c, 1'b0, 16'h0, 8'h01);
    expect_val("post_nop_pc", 32'(pc_m));
    #1;
    check_next(32'(PC));

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed %0d expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
